// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// dmem_responder : RV32I data-memory responder with fixed wait states
// Revision       : 1.0
// ============================================================================
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int XLEN        = 32
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic            req_we_i,
  input  logic [2:0]      req_funct3_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_err_o
);

  localparam int         AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [31:0] word_q;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic          hs, f3_ok, misalign, out_of_range, req_err;
  logic [AW-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   wd, shifted;
  logic [XLEN-1:0] ld;

  assign hs  = req_valid_i && (state_q == S_IDLE);
  assign idx = req_addr_i[AW+1:2];

  always_comb begin
    f3_ok = 1'b0;
    case (req_funct3_i)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = !req_we_i;
      default:                f3_ok = 1'b0;
    endcase
  end

  assign misalign = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                    ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
  assign out_of_range = {2'b00, req_addr_i[XLEN-1:2]} >= XLEN'(DEPTH_WORDS);
  assign req_err      = !f3_ok || misalign || out_of_range;

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    be = 4'b0000;
    wd = req_wdata_i[31:0];
    case (req_funct3_i[1:0])
      2'b00: begin
        be = 4'b0001 << req_addr_i[1:0];
        wd = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        be = 4'b0011 << {req_addr_i[1], 1'b0};
        wd = {2{req_wdata_i[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (hs && req_we_i && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      off_q    <= 2'b00;
      word_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (hs) begin
        err_q    <= req_err;
        we_q     <= req_we_i;
        funct3_q <= req_funct3_i;
        off_q    <= req_addr_i[1:0];
        word_q   <= (req_err || req_we_i) ? 32'd0 : mem_q[idx];
      end
    end
  end

  assign shifted = word_q >> {off_q, 3'b000};

  always_comb begin
    ld = '0;
    case (funct3_q)
      3'b000:  ld = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      3'b001:  ld = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      3'b010:  ld = XLEN'(shifted);
      3'b100:  ld = {{(XLEN-8){1'b0}}, shifted[7:0]};
      3'b101:  ld = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: ld = '0;
    endcase
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_err_o   = rsp_valid_o && err_q;
  assign rsp_rdata_o = (rsp_valid_o && !err_q && !we_q) ? ld : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// tb_dmem_responder : directed self-checking bench for dmem_responder
// Revision          : 1.0
// ============================================================================
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int WAITC = 2;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            rstn_i;
  logic            req_valid_i;
  logic            req_ready_o;
  logic [XLEN-1:0] req_addr_i;
  logic            req_we_i;
  logic [2:0]      req_funct3_i;
  logic [XLEN-1:0] req_wdata_i;
  logic            rsp_valid_o;
  logic            rsp_ready_i;
  logic [XLEN-1:0] rsp_rdata_o;
  logic            rsp_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_CYCLES(WAITC),
    .XLEN       (XLEN)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_we_i    (req_we_i),
    .req_funct3_i(req_funct3_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction; request fields are scrambled right after acceptance.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
    int cyc;
    @(negedge clk);
    check({tag, "/req_ready"}, 32'(req_ready_o), 32'd1);
    req_valid_i  = 1'b1;
    req_we_i     = we;
    req_funct3_i = f3;
    req_addr_i   = addr;
    req_wdata_i  = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid_i  = 1'b0;
    req_we_i     = 1'($urandom);
    req_funct3_i = 3'($urandom);
    req_addr_i   = $urandom;
    req_wdata_i  = $urandom;
    cyc = 1;
    while (!rsp_valid_o && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "/latency"}, 32'(cyc), 32'(WAITC + 1));
    check({tag, "/rdata"}, rsp_rdata_o, exp_rdata);
    check({tag, "/err"}, 32'(rsp_err_o), 32'(exp_err));
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    check({tag, "/idle_ready"}, 32'(req_ready_o), 32'd1);
    check({tag, "/idle_valid"}, 32'(rsp_valid_o), 32'd0);
  endtask

  initial begin
    int cyc;
    rstn_i       = 1'b0;
    req_valid_i  = 1'b0;
    req_addr_i   = '0;
    req_we_i     = 1'b0;
    req_funct3_i = 3'b000;
    req_wdata_i  = '0;
    rsp_ready_i  = 1'b0;

    repeat (3) @(negedge clk);
    check("rst/rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst/rsp_err", 32'(rsp_err_o), 32'd0);
    check("rst/rsp_rdata", rsp_rdata_o, 32'd0);
    rstn_i = 1'b1;
    @(negedge clk);
    check("rst/req_ready", 32'(req_ready_o), 32'd1);

    // Word store/load round trip
    do_req("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    do_req("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Byte store into a cleared word, then signed/unsigned byte loads
    do_req("sw10_clr", 1'b1, 3'b010, 32'h10, 32'h0, 32'h0, 1'b0);
    do_req("sb13", 1'b1, 3'b000, 32'h13, 32'h80, 32'h0, 1'b0);
    do_req("lb13", 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0);
    do_req("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0);
    do_req("lw10_b", 1'b0, 3'b010, 32'h10, 32'h0, 32'h80000000, 1'b0);
    do_req("lh12", 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF8000, 1'b0);
    do_req("lhu12", 1'b0, 3'b101, 32'h12, 32'h0, 32'h00008000, 1'b0);

    // Misalignment and illegal funct3 leave storage untouched
    do_req("lw12_mis", 1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1);
    do_req("sh11_mis", 1'b1, 3'b001, 32'h11, 32'hFFFF, 32'h0, 1'b1);
    do_req("lw10_c", 1'b0, 3'b010, 32'h10, 32'h0, 32'h80000000, 1'b0);
    do_req("f3_011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
    do_req("st_f3_100", 1'b1, 3'b100, 32'h10, 32'h55, 32'h0, 1'b1);
    do_req("lw10_d", 1'b0, 3'b010, 32'h10, 32'h0, 32'h80000000, 1'b0);

    // Lane selection for SB/SH at non-zero offsets
    do_req("sb11", 1'b1, 3'b000, 32'h11, 32'h00ABCD12, 32'h0, 1'b0);
    do_req("lw10_e", 1'b0, 3'b010, 32'h10, 32'h0, 32'h80001200, 1'b0);
    do_req("sh12", 1'b1, 3'b001, 32'h12, 32'h7777BEEF, 32'h0, 1'b0);
    do_req("lh12_b", 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFBEEF, 1'b0);
    do_req("lw10_f", 1'b0, 3'b010, 32'h10, 32'h0, 32'hBEEF1200, 1'b0);

    // Range limit: address 4*DEPTH must not alias word 0
    do_req("sw0", 1'b1, 3'b010, 32'h0, 32'hA5A5A5A5, 32'h0, 1'b0);
    do_req("lw_oor", 1'b0, 3'b010, 32'(4 * DEPTH), 32'h0, 32'h0, 1'b1);
    do_req("sw_oor", 1'b1, 3'b010, 32'(4 * DEPTH), 32'h11111111, 32'h0, 1'b1);

    // Back-pressure: response held for 5 cycles while new requests are offered
    @(negedge clk);
    check("stall/req_ready", 32'(req_ready_o), 32'd1);
    req_valid_i  = 1'b1;
    req_we_i     = 1'b0;
    req_funct3_i = 3'b010;
    req_addr_i   = 32'h0;
    @(posedge clk);
    @(negedge clk);
    req_we_i     = 1'b1;
    req_addr_i   = 32'h10;
    req_wdata_i  = 32'hCAFEF00D;
    cyc = 1;
    while (!rsp_valid_o && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("stall/latency", 32'(cyc), 32'(WAITC + 1));
    for (int i = 0; i < 5; i++) begin
      check("stall/valid", 32'(rsp_valid_o), 32'd1);
      check("stall/rdata", rsp_rdata_o, 32'hA5A5A5A5);
      check("stall/err", 32'(rsp_err_o), 32'd0);
      check("stall/req_ready", 32'(req_ready_o), 32'd0);
      @(negedge clk);
    end
    rsp_ready_i = 1'b1;
    req_valid_i = 1'b0;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    check("stall/idle_ready", 32'(req_ready_o), 32'd1);
    check("stall/idle_valid", 32'(rsp_valid_o), 32'd0);
    do_req("lw10_g", 1'b0, 3'b010, 32'h10, 32'h0, 32'hBEEF1200, 1'b0);

    // Reset during WAIT: committed store survives, response is dropped
    @(negedge clk);
    req_valid_i  = 1'b1;
    req_we_i     = 1'b1;
    req_funct3_i = 3'b010;
    req_addr_i   = 32'h20;
    req_wdata_i  = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    check("rstw/in_wait", 32'(req_ready_o), 32'd0);
    #2;
    rstn_i = 1'b0;
    #1;
    check("rstw/async_ready", 32'(req_ready_o), 32'd1);
    check("rstw/async_valid", 32'(rsp_valid_o), 32'd0);
    @(negedge clk);
    rstn_i = 1'b1;
    repeat (4) @(negedge clk);
    check("rstw/ready_after", 32'(req_ready_o), 32'd1);
    check("rstw/no_resp", 32'(rsp_valid_o), 32'd0);
    do_req("lw20", 1'b0, 3'b010, 32'h20, 32'h0, 32'h12345678, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning number of 32-bit storage words.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning wait states between request acceptance and response; legal values are 0..15.
REQ-003 SHALL have port clk_i  input  1  meaning single clock; all state updates on the rising edge.
REQ-004 SHALL have port rstn_i  input  1  meaning reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid_i  input  1  meaning the core presents a request.
REQ-006 SHALL have port req_ready_o  output  1  meaning the responder can accept a request.
REQ-007 SHALL have port req_addr_i  input  XLEN  meaning byte address.
REQ-008 SHALL have port req_we_i  input  1  meaning 1 = store, 0 = load.
REQ-009 SHALL have port req_funct3_i  input  3  meaning RV32I load/store width code.
REQ-010 SHALL have port req_wdata_i  input  XLEN  meaning store data, right-aligned.
REQ-011 SHALL have port rsp_valid_o  output  1  meaning a response is presented.
REQ-012 SHALL have port rsp_ready_i  input  1  meaning the core accepts the response.
REQ-013 SHALL have port rsp_rdata_o  output  XLEN  meaning load result, extended per funct3; 0 for stores and errors.
REQ-014 SHALL have port rsp_err_o  output  1  meaning the request was rejected.

Function
REQ-015 SHALL implement the states IDLE, WAIT and RESP.
REQ-016 SHALL drive req_ready_o=1 only in IDLE.
REQ-017 SHALL accept a request when req_valid_i and req_ready_o are both 1 on a rising edge; the request is then handshaked.
REQ-018 SHALL, on a handshake, register addr, we, funct3 and wdata.
REQ-019 SHALL, on a handshake, go to WAIT loaded with count WAIT_CYCLES; if WAIT_CYCLES=0 it goes directly to RESP.
REQ-020 SHALL, in WAIT, decrement the count each cycle and go to RESP on the edge where the count equals 1.
REQ-021 SHALL hold rsp_valid_o=1 only in RESP; rsp_rdata_o and rsp_err_o stay stable while rsp_valid_o=1 and rsp_ready_i=0.
REQ-022 SHALL go from RESP to IDLE on the edge where rsp_ready_i=1; no new request is accepted in that same cycle.
REQ-023 SHALL give rsp_valid_o=1 first at cycle N+1+WAIT_CYCLES for a handshake at edge N; back-to-back throughput is one request per WAIT_CYCLES+2 cycles.
REQ-024 SHALL accept only these funct3 codes: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
REQ-025 SHALL flag an error for any other funct3 code, including store funct3 100/101.
REQ-026 SHALL flag a misaligned error for a halfword with addr[0]=1 or a word with addr[1:0]!=00.
REQ-027 SHALL flag a range error when addr[XLEN-1:2] >= DEPTH_WORDS.
REQ-028 SHALL return rsp_err_o=1 and rsp_rdata_o=0 for any error, with no storage modification.
REQ-029 SHALL commit a legal store on the handshake edge, writing only the byte lanes selected by addr[1:0] and the width.
REQ-030 SHALL take a legal store's data from the low bytes of wdata; SB writes lane addr[1:0], SH writes lanes {addr[1],0} and {addr[1],1}.
REQ-031 SHALL capture a legal load's storage word on the handshake edge; the selected byte/half is shifted down by addr[1:0].
REQ-032 SHALL sign-extend loads for LB/LH and zero-extend them for LBU/LHU.
REQ-033 SHALL ignore input changes while not in IDLE.

Reset
REQ-034 SHALL, on rstn_i=0, asynchronously force state IDLE, count 0, rsp_valid_o=0, rsp_err_o=0 and rsp_rdata_o=0.
REQ-035 SHALL have req_ready_o=1 once rstn_i=1.
REQ-036 SHALL not reset storage contents; a store already committed before a reset mid-operation remains, and its pending response is dropped.

Verification
REQ-037 SHALL cover: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_rdata_o=0xDEADBEEF, err=0, rsp_valid_o asserted 3 cycles after each handshake (WAIT_CYCLES=2).
REQ-038 SHALL cover: SB 0x13 data 0x80 over word 0x00000000, then LB 0x13 -> 0xFFFFFF80 and LBU 0x13 -> 0x00000080; LW 0x10 -> 0x80000000.
REQ-039 SHALL cover: LW 0x12 -> err=1, rdata=0; SH 0x11 -> err=1, following LW shows the word unchanged; funct3=011 -> err=1.
REQ-040 SHALL cover: LW at byte address 4*DEPTH_WORDS -> err=1, and no wrap-around write for a store to the same address.
REQ-041 SHALL cover: rsp_ready_i held 0 for 5 cycles in RESP -> rsp_valid_o, rdata and err stable; req_ready_o=0 throughout; IDLE one cycle after rsp_ready_i=1.
REQ-042 SHALL cover: rstn_i pulsed low during WAIT of a SW 0x20 0x12345678 -> rsp_valid_o=0 immediately, req_ready_o=1 after release, and LW 0x20 returns 0x12345678.
